sink_byte_serializer: RTL and testbench
=======================================

# sink_byte_serializer

Converts each spike word produced by the network sink stage into a sequence of bytes for the host transport (UART/byte-stream TX). Sits directly downstream of the network sink: it consumes the `snk_valid`/`snk_ready`/`snk` handshake and drives a byte-wide valid/ready stream toward the transmitter. Each word is held in a shift register and emitted most-significant byte first, so bit ordering on the host side matches the sink's output-index reversal.

## Interface
- `SNK_WIDTH`, default 16: width of the incoming spike word; must be ≥1.
- `BYTE_WIDTH`, default 8: width of the outgoing byte stream.
- Derived: `NUM_BYTES = ceil(SNK_WIDTH / BYTE_WIDTH)`; `IDX_WIDTH = max(1, $clog2(NUM_BYTES))`.

- `clk`  in  1  system clock; one clock, all logic on rising edge
- `arstn`  in  1  reset, asynchronous assert, active-low
- `snk_valid`  in  1  upstream word valid
- `snk_ready`  out  1  serializer can accept a word this cycle
- `snk`  in  SNK_WIDTH  spike word
- `tx_valid`  out  1  `tx_data` holds a valid byte
- `tx_ready`  in  1  transmitter accepts the byte this cycle
- `tx_data`  out  BYTE_WIDTH  current byte

## Operation
- Word acceptance is `snk_valid && snk_ready`. On acceptance, zero-extend `snk` at the MSB end to `NUM_BYTES*BYTE_WIDTH` bits and load it into the shift register. Set `idx` to 0.
- `tx_data` is always the top `BYTE_WIDTH` bits of the shift register.
- Byte transfer is `tx_valid && tx_ready`. On transfer, shift the register left by `BYTE_WIDTH` (zero fill) and increment `idx`.
- FSM has two states, IDLE and SEND.
  - IDLE: `tx_valid`=0 and `snk_ready`=1. On acceptance, go to SEND.
  - SEND: `tx_valid`=1. On the transfer with `idx == NUM_BYTES-1` (last byte):
    - if a new word is accepted in the same cycle, load it and stay in SEND;
    - otherwise go to IDLE.
  - Any other transfer in SEND stays in SEND.
- `snk_ready` = IDLE, or (SEND and `idx == NUM_BYTES-1` and `tx_ready`). This is a combinational path from `tx_ready` and is permitted.
- With `NUM_BYTES == 1`, every byte is the last byte.
- Once `tx_valid` is high, `tx_data` does not change until the byte is transferred (AXI-stream rules). `tx_valid` never depends on `tx_ready`.
- Words are never dropped or reordered. Bytes are never duplicated.

## Timing
- Reset values:
  - state IDLE, `idx` 0, shift register 0
  - `tx_valid` 0, `tx_data` 0, `snk_ready` 1
- Latency: a word accepted at edge t gives its first byte as `tx_valid` from cycle t+1.
- Throughput with `tx_ready` held at 1: one byte per cycle and `NUM_BYTES` cycles per word. There are no bubbles between consecutive words.
- When `tx_ready` is 0, all state is held and `snk_ready` is 0, unless in IDLE.
- If reset asserts mid-word, the outputs go to their reset values immediately. The partially sent word is discarded. After `arstn` deasserts, the first accepted word starts fresh from byte 0.

## Structure
- Shared package `sink_serial_config` holds:
  - `BYTE_WIDTH` default
  - a `num_bytes(width)` constant function
  - the `ser_state_t` enum {IDLE, SEND}
- One module only, with no sub-module. The shift register, `idx` counter and FSM live in a single `always_ff` plus an `always_comb` for `snk_ready`.

## Test plan
- SNK_WIDTH=16, send `0xA5C3` with `tx_ready`=1 → bytes `0xA5`, `0xC3` on consecutive cycles starting 1 cycle after acceptance; `snk_ready` high in the second byte's cycle.
- SNK_WIDTH=12, send `0xABC` → bytes `0x0A`, `0xBC`. Padding bits are zero.
- SNK_WIDTH=16, words `0x1234` and `0x5678` back-to-back with `tx_ready`=1 → `12 34 56 78` with no gap; `tx_valid` continuously 1 for 4 cycles.
- Backpressure: drop `tx_ready` for 5 cycles during byte 0 of `0xBEEF` → `tx_data` holds `0xBE`, `tx_valid` holds 1 and `snk_ready` holds 0; resume → `0xEF`.
- SNK_WIDTH=8, stream 4 words with `tx_ready`=1 → 4 bytes in 4 consecutive cycles, `snk_ready` constantly 1.
- Assert `arstn` low after byte 0 of `0xCAFE` → `tx_valid` is 0 immediately; after release, send `0x0102` → `01 02` only, with no `0xFE` emitted.

Source files
------------

// File: rtl/sink_byte_serializer_pkg.sv
// Package sink_serial_config
// Shared configuration for the spike-word-to-byte serializer:
//   DEFAULT_BYTE_WIDTH - default outgoing byte width
//   num_bytes()        - bytes needed to carry a word of a given width
//   ser_state_t        - serializer FSM states
package sink_serial_config;

    localparam int unsigned DEFAULT_BYTE_WIDTH = 8;

    // Round up so a partial top byte still gets its own transfer.
    function automatic int unsigned num_bytes(
        input int unsigned width,
        input int unsigned byte_width = DEFAULT_BYTE_WIDTH
    );
        return (width + byte_width - 1) / byte_width;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/sink_byte_serializer.sv
// sink_byte_serializer
// Splits each spike word from the network sink into bytes, most-significant
// byte first, for a byte-stream transmitter.
// Ports:
//   clk        system clock, rising edge
//   arstn      asynchronous active-low reset
//   snk_valid  upstream word valid
//   snk_ready  serializer can take a word this cycle
//   snk        spike word (SNK_WIDTH bits)
//   tx_valid   tx_data holds a valid byte
//   tx_ready   transmitter takes the byte this cycle
//   tx_data    current byte (BYTE_WIDTH bits)
module sink_byte_serializer
    import sink_serial_config::*;
#(
    parameter int unsigned SNK_WIDTH  = 16,
    parameter int unsigned BYTE_WIDTH = DEFAULT_BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  snk_valid,
    output logic                  snk_ready,
    input  logic [SNK_WIDTH-1:0]  snk,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [BYTE_WIDTH-1:0] tx_data
);

    localparam int unsigned NUM_BYTES = num_bytes(SNK_WIDTH, BYTE_WIDTH);
    localparam int unsigned SR_WIDTH  = NUM_BYTES * BYTE_WIDTH;
    localparam int unsigned IDX_WIDTH = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_BYTES - 1);

    ser_state_t            state_q, state_d;
    logic [IDX_WIDTH-1:0]  idx_q;
    logic [SR_WIDTH-1:0]   sr_q;
    logic                  last_byte;
    logic                  accept;
    logic                  xfer;

    assign tx_data = sr_q[SR_WIDTH-1 -: BYTE_WIDTH];

    always_comb begin
        last_byte = (idx_q == LAST_IDX);
        tx_valid  = (state_q == SEND);
        // A new word may be taken while the last byte of the current one
        // leaves, which keeps back-to-back words bubble-free.
        snk_ready = (state_q == IDLE) || (last_byte && tx_ready);
        accept    = snk_valid && snk_ready;
        xfer      = tx_valid && tx_ready;
        state_d   = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = SEND;
            SEND: if (xfer && last_byte && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                sr_q  <= SR_WIDTH'(snk);
                idx_q <= '0;
            end else if (xfer) begin
                sr_q  <= sr_q << BYTE_WIDTH;
                idx_q <= idx_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sink_byte_serializer.sv
// tb_sink_byte_serializer
// Drives three serializer instances (16-, 12- and 8-bit words, 8-bit bytes)
// and compares them against a byte-queue reference model plus directed
// sequences for latency, back-to-back, backpressure and reset cases.
module tb_sink_byte_serializer;

    logic        clk;
    logic        arstn;
    logic        sv [3];
    logic        sr [3];
    logic [15:0] s  [3];
    logic        tv [3];
    logic        tr [3];
    logic [7:0]  td [3];

    int n_checks;
    int n_errors;

    // Reference model: bytes accepted but not yet transferred, per instance.
    logic [7:0] exp_q [3][$];
    logic       hold_pending [3];
    logic [7:0] hold_data [3];
    int         nbytes [3];
    int         wwidth [3];

    sink_byte_serializer #(.SNK_WIDTH(16), .BYTE_WIDTH(8)) dut16 (
        .clk(clk), .arstn(arstn), .snk_valid(sv[0]), .snk_ready(sr[0]),
        .snk(s[0]), .tx_valid(tv[0]), .tx_ready(tr[0]), .tx_data(td[0])
    );
    sink_byte_serializer #(.SNK_WIDTH(12), .BYTE_WIDTH(8)) dut12 (
        .clk(clk), .arstn(arstn), .snk_valid(sv[1]), .snk_ready(sr[1]),
        .snk(s[1][11:0]), .tx_valid(tv[1]), .tx_ready(tr[1]), .tx_data(td[1])
    );
    sink_byte_serializer #(.SNK_WIDTH(8), .BYTE_WIDTH(8)) dut8 (
        .clk(clk), .arstn(arstn), .snk_valid(sv[2]), .snk_ready(sr[2]),
        .snk(s[2][7:0]), .tx_valid(tv[2]), .tx_ready(tr[2]), .tx_data(td[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model step for one instance, evaluated mid-cycle before the next edge.
    task automatic mon(input int d);
        int unsigned qs;
        logic        exp_rdy;
        logic [15:0] w;
        logic [7:0]  b;
        qs      = exp_q[d].size();
        exp_rdy = (qs == 0) || (qs == 1 && tr[d]);
        chk($sformatf("mon%0d tx_valid", d), 32'(tv[d]), 32'(qs != 0));
        chk($sformatf("mon%0d snk_ready", d), 32'(sr[d]), 32'(exp_rdy));
        if (hold_pending[d]) begin
            chk($sformatf("mon%0d hold_valid", d), 32'(tv[d]), 32'd1);
            chk($sformatf("mon%0d hold_data", d), 32'(td[d]), 32'(hold_data[d]));
        end
        hold_pending[d] = tv[d] && !tr[d];
        hold_data[d]    = td[d];
        if (tv[d] && tr[d] && qs > 0) begin
            b = exp_q[d].pop_front();
            chk($sformatf("mon%0d byte", d), 32'(td[d]), 32'(b));
        end
        if (sv[d] && sr[d]) begin
            w = s[d] & 16'((32'd1 << wwidth[d]) - 1);
            for (int i = nbytes[d] - 1; i >= 0; i--)
                exp_q[d].push_back(8'(w >> (8 * i)));
        end
    endtask

    always @(negedge clk) begin
        if (arstn) begin
            for (int d = 0; d < 3; d++) mon(d);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model;
        for (int d = 0; d < 3; d++) begin
            exp_q[d].delete();
            hold_pending[d] = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s%0d tx_valid", tag, d), 32'(tv[d]), 32'd0);
            chk($sformatf("%s%0d tx_data", tag, d), 32'(td[d]), 32'd0);
            chk($sformatf("%s%0d snk_ready", tag, d), 32'(sr[d]), 32'd1);
        end
    endtask

    typedef struct {
        int              d;
        logic [15:0]     word;
        int              nb;
        logic [1:0][7:0] b;
    } vec_t;

    task automatic run_vec(input vec_t v, input int k);
        tick();
        sv[v.d] = 1'b1; s[v.d] = v.word; tr[v.d] = 1'b1;
        tick();
        sv[v.d] = 1'b0;
        for (int i = 0; i < v.nb; i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d valid%0d", k, i), 32'(tv[v.d]), 32'd1);
            chk($sformatf("vec%0d byte%0d", k, i), 32'(td[v.d]), 32'(v.b[1 - i]));
        end
        chk($sformatf("vec%0d ready_last", k), 32'(sr[v.d]), 32'd1);
        @(negedge clk);
        chk($sformatf("vec%0d idle", k), 32'(tv[v.d]), 32'd0);
    endtask

    vec_t vecs [5];

    initial begin
        n_checks = 0;
        n_errors = 0;
        nbytes = '{2, 2, 1};
        wwidth = '{16, 12, 8};
        for (int d = 0; d < 3; d++) begin
            sv[d] = 1'b0; s[d] = '0; tr[d] = 1'b0;
        end
        clear_model();
        arstn = 1'b0;
        #12;
        check_reset_outputs("reset");
        for (int d = 0; d < 3; d++) tr[d] = 1'b1;
        @(negedge clk);
        #2 arstn = 1'b1;

        // Single words with tx_ready held high.
        vecs[0] = '{d: 0, word: 16'hA5C3, nb: 2, b: {8'hA5, 8'hC3}};
        vecs[1] = '{d: 1, word: 16'h0ABC, nb: 2, b: {8'h0A, 8'hBC}};
        vecs[2] = '{d: 2, word: 16'h005A, nb: 1, b: {8'h5A, 8'h00}};
        vecs[3] = '{d: 1, word: 16'hFFFF, nb: 2, b: {8'h0F, 8'hFF}};
        vecs[4] = '{d: 0, word: 16'h00FF, nb: 2, b: {8'h00, 8'hFF}};
        for (int k = 0; k < 5; k++) run_vec(vecs[k], k);

        // Back-to-back words: 12 34 56 78 with no gap.
        tick();
        sv[0] = 1'b1; s[0] = 16'h1234;
        tick();
        s[0] = 16'h5678;
        @(negedge clk);
        chk("b2b byte0", 32'(td[0]), 32'h12);
        chk("b2b ready0", 32'(sr[0]), 32'd0);
        @(negedge clk);
        chk("b2b byte1", 32'(td[0]), 32'h34);
        chk("b2b ready1", 32'(sr[0]), 32'd1);
        tick();
        sv[0] = 1'b0;
        @(negedge clk);
        chk("b2b valid2", 32'(tv[0]), 32'd1);
        chk("b2b byte2", 32'(td[0]), 32'h56);
        @(negedge clk);
        chk("b2b valid3", 32'(tv[0]), 32'd1);
        chk("b2b byte3", 32'(td[0]), 32'h78);
        @(negedge clk);
        chk("b2b idle", 32'(tv[0]), 32'd0);

        // Backpressure during byte 0 of 0xBEEF.
        tick();
        sv[0] = 1'b1; s[0] = 16'hBEEF; tr[0] = 1'b0;
        tick();
        sv[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp valid", 32'(tv[0]), 32'd1);
            chk("bp data", 32'(td[0]), 32'hBE);
            chk("bp ready", 32'(sr[0]), 32'd0);
        end
        tick();
        tr[0] = 1'b1;
        @(negedge clk);
        chk("bp byte0", 32'(td[0]), 32'hBE);
        @(negedge clk);
        chk("bp byte1", 32'(td[0]), 32'hEF);
        @(negedge clk);
        chk("bp idle", 32'(tv[0]), 32'd0);

        // 8-bit words streamed every cycle.
        tick();
        sv[2] = 1'b1; s[2] = 16'h0011;
        for (int i = 1; i < 4; i++) begin
            tick();
            s[2] = 16'(8'h11 * (i + 1));
            @(negedge clk);
            chk("stream8 ready", 32'(sr[2]), 32'd1);
            chk("stream8 valid", 32'(tv[2]), 32'd1);
            chk("stream8 byte", 32'(td[2]), 32'(8'h11 * i));
        end
        tick();
        sv[2] = 1'b0;
        @(negedge clk);
        chk("stream8 last", 32'(td[2]), 32'h44);
        @(negedge clk);
        chk("stream8 idle", 32'(tv[2]), 32'd0);

        // Reset after byte 0 of 0xCAFE; the 0xFE byte must never appear.
        tick();
        sv[0] = 1'b1; s[0] = 16'hCAFE;
        tick();
        sv[0] = 1'b0;
        @(negedge clk);
        chk("rst byte0", 32'(td[0]), 32'hCA);
        tick();
        arstn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        clear_model();
        @(negedge clk);
        #2 arstn = 1'b1;
        tick();
        sv[0] = 1'b1; s[0] = 16'h0102;
        tick();
        sv[0] = 1'b0;
        @(negedge clk);
        chk("rst new0", 32'(td[0]), 32'h01);
        @(negedge clk);
        chk("rst new1", 32'(td[0]), 32'h02);
        @(negedge clk);
        chk("rst idle", 32'(tv[0]), 32'd0);

        // Random traffic on all instances against the queue model.
        for (int c = 0; c < 1500; c++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                sv[d] = 1'($urandom_range(0, 1));
                s[d]  = 16'($urandom);
                tr[d] = ($urandom_range(0, 3) != 0);
            end
        end
        tick();
        for (int d = 0; d < 3; d++) begin
            sv[d] = 1'b0; tr[d] = 1'b1;
        end
        for (int c = 0; c < 4; c++) tick();
        @(negedge clk);
        for (int d = 0; d < 3; d++)
            chk($sformatf("drain%0d", d), 32'(exp_q[d].size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
